ahb_resp_mux_n: RTL and testbench

- Parametrised AHB-Lite data-phase response multiplexor for N slaves, placed between the slave array and the master.
- Registers the decoder's address-phase select and holds it for the data phase.
- Routes the owning slave's hrdata/hreadyout/hresp back to the master.
- Contains a built-in default slave: zero-wait OKAY for IDLE/BUSY transfers, and a two-cycle ERROR response for transfers to unmapped addresses.

---
 rtl/ahb_resp_mux_n.sv | 124 ++++++++++++
 tb/tb_ahb_resp_mux_n.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ahb_resp_mux_n.sv
// AHB-Lite data-phase response multiplexor for NUM_SLAVES slaves.
// Registers the decoder's address-phase select and holds it for the
// data phase. Routes the owning slave's hrdata/hreadyout/hresp back to
// the master. A built-in default slave answers IDLE/BUSY transfers with
// a zero-wait OKAY, and unmapped transfers with a two-cycle ERROR.
module ahb_resp_mux_n #(
   parameter int NUM_SLAVES = 4,
   parameter int DATA_WIDTH = 32,
   parameter int SEL_WIDTH  = 2
) (
   input  logic                             hclk,
   input  logic                             hreset,
   input  logic [SEL_WIDTH-1:0]             hsel_addr,
   input  logic                             hsel_valid,
   input  logic [1:0]                       htrans,
   input  logic [NUM_SLAVES*DATA_WIDTH-1:0] hrdata_bus,
   input  logic [NUM_SLAVES-1:0]            hreadyout_bus,
   input  logic [NUM_SLAVES-1:0]            hresp_bus,
   output logic [DATA_WIDTH-1:0]            hrdata,
   output logic                             hready,
   output logic                             hresp,
   output logic [SEL_WIDTH:0]               data_owner
);

   typedef enum logic [1:0] {
      DEF_OK = 2'd0,   // default slave, zero-wait OKAY
      SLAVE  = 2'd1,   // a mapped slave owns the data phase
      ERR1   = 2'd2,   // default-slave ERROR, first cycle (not ready)
      ERR2   = 2'd3    // default-slave ERROR, second cycle (ready)
   } state_t;

   // Owner code of the default slave: MSB set, index bits zero.
   localparam logic [SEL_WIDTH:0] OWNER_DEF    = {1'b1, {SEL_WIDTH{1'b0}}};
   // One extra bit so the range check stays meaningful when every code is mapped.
   localparam logic [SEL_WIDTH:0] NUM_SLAVES_W = (SEL_WIDTH+1)'(NUM_SLAVES);

   state_t                 state_q, state_d;
   logic [SEL_WIDTH:0]     owner_q, owner_d;

   logic [DATA_WIDTH-1:0]  slv_rdata;
   logic                   slv_ready;
   logic                   slv_resp;
   logic                   xfer_active;
   logic                   addr_mapped;

   // Select the owning slave's response slice; unmatched owners give defined zeros.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no latch can be inferred.
      slv_rdata = '0;
      slv_ready = 1'b1;
      slv_resp  = 1'b0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (owner_q == (SEL_WIDTH+1)'(i)) begin
            slv_rdata = hrdata_bus[i*DATA_WIDTH +: DATA_WIDTH];
            slv_ready = hreadyout_bus[i];
            slv_resp  = hresp_bus[i];
         end
      end
   end

   // Drive the master-side response from the registered data-phase state.
   always_comb begin
      hrdata = '0;
      hready = 1'b1;
      hresp  = 1'b0;
      unique case (state_q)
         SLAVE: begin
            hrdata = slv_rdata;
            hready = slv_ready;
            hresp  = slv_resp;
         end
         ERR1: begin
            hready = 1'b0;
            hresp  = 1'b1;
         end
         ERR2: begin
            hready = 1'b1;
            hresp  = 1'b1;
         end
         default: begin
            hready = 1'b1;
            hresp  = 1'b0;
         end
      endcase
   end

   assign xfer_active = (htrans == 2'b10) || (htrans == 2'b11);
   assign addr_mapped = hsel_valid && ({1'b0, hsel_addr} < NUM_SLAVES_W);

   // Next owner/state: sample the address phase whenever the bus is ready.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      if (state_q == ERR1) begin
         state_d = ERR2;
      end else if (hready) begin
         if (!xfer_active) begin
            state_d = DEF_OK;
            owner_d = OWNER_DEF;
         end else if (addr_mapped) begin
            state_d = SLAVE;
            owner_d = {1'b0, hsel_addr};
         end else begin
            state_d = ERR1;
            owner_d = OWNER_DEF;
         end
      end
   end

   // Data-phase owner and state registers; reset parks the bus on the default slave.
   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         state_q <= DEF_OK;
         owner_q <= OWNER_DEF;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         state_q <= state_d;
         owner_q <= owner_d;
      end
   end

   assign data_owner = owner_q;

endmodule

// File: tb/tb_ahb_resp_mux_n.sv
// Self-checking bench for ahb_resp_mux_n: a table of per-cycle vectors on
// a 4-slave instance, plus hand-written sequences for an out-of-range
// select on a 3-slave instance and a reset that aborts an ERROR response.
module tb_ahb_resp_mux_n;

   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] BUSY = 2'b01;
   localparam logic [1:0] NSEQ = 2'b10;
   localparam logic [1:0] SEQ  = 2'b11;

   logic          hclk = 1'b0;
   logic          hreset;
   logic [1:0]    hsel_addr;
   logic          hsel_valid;
   logic [1:0]    htrans;
   logic [127:0]  hrdata_bus;
   logic [3:0]    hreadyout_bus;
   logic [3:0]    hresp_bus;
   logic [31:0]   hrdata;
   logic          hready;
   logic          hresp;
   logic [2:0]    data_owner;

   logic [31:0]   hrdata3;
   logic          hready3;
   logic          hresp3;
   logic [2:0]    data_owner3;

   int n_cmp = 0;
   int n_err = 0;

   always #5 hclk = ~hclk;

   ahb_resp_mux_n #(.NUM_SLAVES(4), .DATA_WIDTH(32), .SEL_WIDTH(2)) dut (
      .hclk          (hclk),
      .hreset        (hreset),
      .hsel_addr     (hsel_addr),
      .hsel_valid    (hsel_valid),
      .htrans        (htrans),
      .hrdata_bus    (hrdata_bus),
      .hreadyout_bus (hreadyout_bus),
      .hresp_bus     (hresp_bus),
      .hrdata        (hrdata),
      .hready        (hready),
      .hresp         (hresp),
      .data_owner    (data_owner)
   );

   ahb_resp_mux_n #(.NUM_SLAVES(3), .DATA_WIDTH(32), .SEL_WIDTH(2)) dut3 (
      .hclk          (hclk),
      .hreset        (hreset),
      .hsel_addr     (hsel_addr),
      .hsel_valid    (hsel_valid),
      .htrans        (htrans),
      .hrdata_bus    (hrdata_bus[95:0]),
      .hreadyout_bus (hreadyout_bus[2:0]),
      .hresp_bus     (hresp_bus[2:0]),
      .hrdata        (hrdata3),
      .hready        (hready3),
      .hresp         (hresp3),
      .data_owner    (data_owner3)
   );

   typedef struct {
      logic [1:0]  trans;
      logic [1:0]  addr;
      logic        valid;
      logic [3:0]  rdy;
      logic [3:0]  resp;
      logic [31:0] e_rd;
      logic        e_rdy;
      logic        e_resp;
      logic [2:0]  e_own;
   } vec_t;

   vec_t vecs [23];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [1:0] t, input logic [1:0] a, input logic v,
                        input logic [3:0] r, input logic [3:0] e);
      htrans        = t;
      hsel_addr     = a;
      hsel_valid    = v;
      hreadyout_bus = r;
      hresp_bus     = e;
   endtask

   task automatic check_main(input string tag, input logic [31:0] rd, input logic rdy,
                             input logic rsp, input logic [2:0] own);
      check({tag, ".hrdata"},     64'(hrdata),     64'(rd));
      check({tag, ".hready"},     64'(hready),     64'(rdy));
      check({tag, ".hresp"},      64'(hresp),      64'(rsp));
      check({tag, ".data_owner"}, 64'(data_owner), 64'(own));
   endtask

   task automatic check_dut3(input string tag, input logic [31:0] rd, input logic rdy,
                             input logic rsp, input logic [2:0] own);
      check({tag, ".hrdata3"},     64'(hrdata3),     64'(rd));
      check({tag, ".hready3"},     64'(hready3),     64'(rdy));
      check({tag, ".hresp3"},      64'(hresp3),      64'(rsp));
      check({tag, ".data_owner3"}, 64'(data_owner3), 64'(own));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Slave read data: s3=33, s2=CAFE_0002, s1=55, s0=11.
      hrdata_bus = {32'h0000_0033, 32'hCAFE_0002, 32'h0000_0055, 32'h0000_0011};

      // Each row: inputs driven in a cycle, outputs expected in that same cycle.
      vecs[0]  = '{IDLE, 2'd0, 1'b0, 4'b1111, 4'b0000, 32'h0,         1'b1, 1'b0, 3'b100};
      vecs[1]  = '{IDLE, 2'd0, 1'b0, 4'b1111, 4'b0000, 32'h0,         1'b1, 1'b0, 3'b100};
      vecs[2]  = '{IDLE, 2'd0, 1'b0, 4'b1111, 4'b0000, 32'h0,         1'b1, 1'b0, 3'b100};
      vecs[3]  = '{NSEQ, 2'd2, 1'b1, 4'b1111, 4'b0000, 32'h0,         1'b1, 1'b0, 3'b100};
      vecs[4]  = '{NSEQ, 2'd0, 1'b1, 4'b1011, 4'b0000, 32'hCAFE_0002, 1'b0, 1'b0, 3'b010};
      vecs[5]  = '{NSEQ, 2'd0, 1'b1, 4'b1011, 4'b0000, 32'hCAFE_0002, 1'b0, 1'b0, 3'b010};
      vecs[6]  = '{NSEQ, 2'd0, 1'b1, 4'b1111, 4'b0000, 32'hCAFE_0002, 1'b1, 1'b0, 3'b010};
      vecs[7]  = '{SEQ,  2'd3, 1'b1, 4'b1111, 4'b0000, 32'h11,        1'b1, 1'b0, 3'b000};
      vecs[8]  = '{IDLE, 2'd0, 1'b0, 4'b1111, 4'b0000, 32'h33,        1'b1, 1'b0, 3'b011};
      vecs[9]  = '{NSEQ, 2'd1, 1'b0, 4'b1111, 4'b0000, 32'h0,         1'b1, 1'b0, 3'b100};
      vecs[10] = '{IDLE, 2'd0, 1'b0, 4'b1111, 4'b0000, 32'h0,         1'b0, 1'b1, 3'b100};
      vecs[11] = '{IDLE, 2'd0, 1'b0, 4'b1111, 4'b0000, 32'h0,         1'b1, 1'b1, 3'b100};
      vecs[12] = '{IDLE, 2'd0, 1'b0, 4'b1111, 4'b0000, 32'h0,         1'b1, 1'b0, 3'b100};
      vecs[13] = '{NSEQ, 2'd1, 1'b1, 4'b1111, 4'b0000, 32'h0,         1'b1, 1'b0, 3'b100};
      vecs[14] = '{IDLE, 2'd0, 1'b0, 4'b1101, 4'b0010, 32'h55,        1'b0, 1'b1, 3'b001};
      vecs[15] = '{IDLE, 2'd0, 1'b0, 4'b1111, 4'b0010, 32'h55,        1'b1, 1'b1, 3'b001};
      vecs[16] = '{BUSY, 2'd3, 1'b1, 4'b1111, 4'b0000, 32'h0,         1'b1, 1'b0, 3'b100};
      vecs[17] = '{IDLE, 2'd0, 1'b0, 4'b1111, 4'b0000, 32'h0,         1'b1, 1'b0, 3'b100};
      vecs[18] = '{NSEQ, 2'd2, 1'b0, 4'b1111, 4'b0000, 32'h0,         1'b1, 1'b0, 3'b100};
      vecs[19] = '{NSEQ, 2'd3, 1'b1, 4'b1111, 4'b0000, 32'h0,         1'b0, 1'b1, 3'b100};
      vecs[20] = '{NSEQ, 2'd3, 1'b1, 4'b1111, 4'b0000, 32'h0,         1'b1, 1'b1, 3'b100};
      vecs[21] = '{IDLE, 2'd0, 1'b0, 4'b1111, 4'b0001, 32'h33,        1'b1, 1'b0, 3'b011};
      vecs[22] = '{IDLE, 2'd0, 1'b0, 4'b1111, 4'b0000, 32'h0,         1'b1, 1'b0, 3'b100};

      // Reset state, checked while reset is held.
      hreset = 1'b1;
      drive(IDLE, 2'd0, 1'b0, 4'b1111, 4'b0000);
      @(negedge hclk);
      check_main("reset", 32'h0, 1'b1, 1'b0, 3'b100);
      check_dut3("reset", 32'h0, 1'b1, 1'b0, 3'b100);
      @(posedge hclk);
      #1 hreset = 1'b0;

      // Table-driven per-cycle vectors on the 4-slave instance.
      for (int i = 0; i < 23; i++) begin
         drive(vecs[i].trans, vecs[i].addr, vecs[i].valid, vecs[i].rdy, vecs[i].resp);
         @(negedge hclk);
         check_main($sformatf("vec%0d", i), vecs[i].e_rd, vecs[i].e_rdy,
                    vecs[i].e_resp, vecs[i].e_own);
         @(posedge hclk);
         #1;
      end

      // Out-of-range index on the 3-slave instance: select 3 is unmapped there.
      hreset = 1'b1;
      #1 hreset = 1'b0;
      drive(NSEQ, 2'd3, 1'b1, 4'b1111, 4'b0000);
      @(negedge hclk);
      check_dut3("oor.addr", 32'h0, 1'b1, 1'b0, 3'b100);
      @(posedge hclk);
      #1 drive(IDLE, 2'd0, 1'b0, 4'b0111, 4'b1000);
      @(negedge hclk);
      check_dut3("oor.err1", 32'h0, 1'b0, 1'b1, 3'b100);
      check_main("oor.slave3", 32'h33, 1'b0, 1'b1, 3'b011);
      @(posedge hclk);
      #1 drive(IDLE, 2'd0, 1'b0, 4'b1111, 4'b0000);
      @(negedge hclk);
      check_dut3("oor.err2", 32'h0, 1'b1, 1'b1, 3'b100);
      @(posedge hclk);
      #1;
      @(negedge hclk);
      check_dut3("oor.idle", 32'h0, 1'b1, 1'b0, 3'b100);
      @(posedge hclk);
      #1;

      // Reset asserted during ERR1 must clear outputs without a clock edge.
      drive(NSEQ, 2'd0, 1'b0, 4'b1111, 4'b0000);
      @(negedge hclk);
      check_main("rst.addr", 32'h0, 1'b1, 1'b0, 3'b100);
      @(posedge hclk);
      #1 drive(IDLE, 2'd0, 1'b0, 4'b1111, 4'b0000);
      @(negedge hclk);
      check_main("rst.err1", 32'h0, 1'b0, 1'b1, 3'b100);
      #1 hreset = 1'b1;
      #1;
      check_main("rst.async", 32'h0, 1'b1, 1'b0, 3'b100);
      @(posedge hclk);
      #1 hreset = 1'b0;
      drive(NSEQ, 2'd1, 1'b1, 4'b1111, 4'b0000);
      @(negedge hclk);
      check_main("rst.nseq", 32'h0, 1'b1, 1'b0, 3'b100);
      @(posedge hclk);
      #1 drive(IDLE, 2'd0, 1'b0, 4'b1111, 4'b0000);
      @(negedge hclk);
      check_main("rst.slave1", 32'h55, 1'b1, 1'b0, 3'b001);
      @(posedge hclk);
      #1;
      @(negedge hclk);
      check_main("rst.idle", 32'h0, 1'b1, 1'b0, 3'b100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
